// File: rtl/motor_pwm_driver_pkg.sv
// rtl/motor_pwm_driver_pkg.sv - shared state encoding and defaults for the motor PWM driver
package motor_pwm_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int DEFAULT_N_WIDTH  = 8;
    localparam int DEFAULT_PERIOD   = 255;
    localparam int DEFAULT_DEADTIME = 4;

    // A zero dead time still needs a one-bit counter.
    function automatic int dcnt_width(input int deadtime);
        return (deadtime > 0) ? $clog2(deadtime + 1) : 1;
    endfunction

endpackage

// File: rtl/motor_pwm_driver_edge_tick_sync.sv
// rtl/motor_pwm_driver_edge_tick_sync.sv - two-flop synchronizer with rising-edge one-cycle tick
module edge_tick_sync (
    input  logic CLOCK_IN,
    input  logic RESET_N,
    input  logic ASYNC_IN,
    output logic TICK
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = ASYNC_IN;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign TICK = s2_q & ~s3_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - H-bridge PWM driver with shadowed duty and dead-time on reversal
module motor_pwm_driver
    import motor_pwm_driver_pkg::*;
#(
    parameter int N_WIDTH  = DEFAULT_N_WIDTH,
    parameter int PERIOD   = DEFAULT_PERIOD,
    parameter int DEADTIME = DEFAULT_DEADTIME
) (
    input  logic               CLOCK_IN,
    input  logic               RESET_N,
    input  logic               PRESCALER_CLK,
    input  logic               ENABLE,
    input  logic [N_WIDTH-1:0] DUTY,
    input  logic               DIR,
    output logic               PWM_OUT,
    output logic               BRIDGE_IN1,
    output logic               BRIDGE_IN2,
    output logic               PERIOD_END,
    output logic               DEAD_ACTIVE
);

    localparam int                  DCNT_W    = dcnt_width(DEADTIME);
    localparam logic [N_WIDTH-1:0]  CNT_MAX   = N_WIDTH'(PERIOD);
    localparam logic [DCNT_W-1:0]   DCNT_INIT = DCNT_W'(DEADTIME);

    logic               tick;
    state_t             state_q, state_d;
    logic [N_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_WIDTH-1:0] duty_q, duty_d;
    logic               dir_q, dir_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic               pwm_q, pwm_d;
    logic               in1_q, in1_d;
    logic               in2_q, in2_d;
    logic               pend_q, pend_d;
    logic               dead_q, dead_d;

    edge_tick_sync u_tick (
        .CLOCK_IN (CLOCK_IN),
        .RESET_N  (RESET_N),
        .ASYNC_IN (PRESCALER_CLK),
        .TICK     (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        dcnt_d  = dcnt_q;
        pend_d  = 1'b0;
        if (!ENABLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    duty_d  = DUTY;
                    dir_d   = DIR;
                end
                ST_RUN: begin
                    if (DIR != dir_q) begin
                        state_d = ST_DEAD;
                        cnt_d   = '0;
                        dcnt_d  = DCNT_INIT;
                    end else if (tick) begin
                        if (cnt_q == CNT_MAX) begin
                            cnt_d  = '0;
                            pend_d = 1'b1;
                            duty_d = DUTY;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (dcnt_q == '0) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        dir_d   = DIR;
                        duty_d  = DUTY;
                    end else if (tick) begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // Outputs follow the next state so a reversal or disable blanks the bridge on the same edge.
        pwm_d  = (state_d == ST_RUN) && (cnt_d < duty_d);
        in1_d  = pwm_d & ~dir_d;
        in2_d  = pwm_d & dir_d;
        dead_d = (state_d == ST_DEAD);
    end

    always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            dcnt_q  <= '0;
            pwm_q   <= 1'b0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
            pend_q  <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            dcnt_q  <= dcnt_d;
            pwm_q   <= pwm_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            pend_q  <= pend_d;
            dead_q  <= dead_d;
        end
    end

    assign PWM_OUT     = pwm_q;
    assign BRIDGE_IN1  = in1_q;
    assign BRIDGE_IN2  = in2_q;
    assign PERIOD_END  = pend_q;
    assign DEAD_ACTIVE = dead_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - scoreboard bench for motor_pwm_driver
module tb_motor_pwm_driver;

    localparam int NW   = 4;
    localparam int PER  = 9;
    localparam int DT   = 2;
    localparam int TCYC = 8;

    logic          CLOCK_IN      = 1'b0;
    logic          RESET_N       = 1'b0;
    logic          PRESCALER_CLK = 1'b0;
    logic          ENABLE        = 1'b0;
    logic [NW-1:0] DUTY          = '0;
    logic          DIR           = 1'b0;
    logic          PWM_OUT, BRIDGE_IN1, BRIDGE_IN2, PERIOD_END, DEAD_ACTIVE;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   hi;
        logic dir;
    } exp_t;
    exp_t exp_q[$];
    exp_t cur;
    bit   open = 1'b0;
    int   p_len, c1, c2;

    int duty_seq[5] = '{7, 0, 15, 10, 1};
    int seq_i = 0;

    motor_pwm_driver #(.N_WIDTH(NW), .PERIOD(PER), .DEADTIME(DT)) dut (
        .CLOCK_IN      (CLOCK_IN),
        .RESET_N       (RESET_N),
        .PRESCALER_CLK (PRESCALER_CLK),
        .ENABLE        (ENABLE),
        .DUTY          (DUTY),
        .DIR           (DIR),
        .PWM_OUT       (PWM_OUT),
        .BRIDGE_IN1    (BRIDGE_IN1),
        .BRIDGE_IN2    (BRIDGE_IN2),
        .PERIOD_END    (PERIOD_END),
        .DEAD_ACTIVE   (DEAD_ACTIVE)
    );

    always #5 CLOCK_IN = ~CLOCK_IN;

    always begin
        repeat (TCYC / 2) @(posedge CLOCK_IN);
        #2 PRESCALER_CLK = ~PRESCALER_CLK;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int outs();
        return int'({PWM_OUT, BRIDGE_IN1, BRIDGE_IN2, PERIOD_END, DEAD_ACTIVE});
    endfunction

    // Reference: a full period is (PER+1) ticks; high time is DUTY ticks, saturating at a full period.
    always @(negedge CLOCK_IN) begin
        if (RESET_N && ENABLE && !DEAD_ACTIVE && PERIOD_END)
            exp_q.push_back('{hi: ((int'(DUTY) > PER) ? PER + 1 : int'(DUTY)) * TCYC, dir: DIR});
    end

    always @(negedge CLOCK_IN) begin
        if (!RESET_N || !ENABLE || DEAD_ACTIVE) begin
            if (open && exp_q.size() > 0) cur = exp_q.pop_front();
            open = 1'b0;
        end else if (PERIOD_END) begin
            if (open) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 0, 1);
                end else begin
                    cur = exp_q.pop_front();
                    check("period_len", p_len, (PER + 1) * TCYC);
                    check("in1_high_cycles", c1, cur.dir ? 0 : cur.hi);
                    check("in2_high_cycles", c2, cur.dir ? cur.hi : 0);
                end
            end
            open  = 1'b1;
            p_len = 0;
            c1    = 0;
            c2    = 0;
        end
        if (open) begin
            p_len++;
            c1 += int'(BRIDGE_IN1);
            c2 += int'(BRIDGE_IN2);
        end
        check("in1_in2_exclusive", int'(BRIDGE_IN1 & BRIDGE_IN2), 0);
        if (DEAD_ACTIVE)
            check("dead_outputs_low", int'({PWM_OUT, BRIDGE_IN1, BRIDGE_IN2, PERIOD_END}), 0);
    end

    task automatic wait_pe();
        int n = 0;
        do begin
            @(negedge CLOCK_IN);
            n++;
        end while (!PERIOD_END && n < 300);
        if (!PERIOD_END) check("wait_period_end_timeout", n, 0);
    endtask

    // Counting from the first cycle of RUN, the first wrap needs a partial tick plus PER full ticks.
    task automatic first_wrap(input string tag);
        int n = 0;
        while (!PERIOD_END && n < 200) begin
            @(negedge CLOCK_IN);
            n++;
        end
        check_range({tag, "_first_wrap"}, n, PER * TCYC + 1, (PER + 1) * TCYC);
    endtask

    task automatic enable_start(input string tag);
        #1 ENABLE = 1'b1;
        @(negedge CLOCK_IN);
        check({tag, "_pwm_first"}, int'(PWM_OUT), int'(DUTY != 0));
        check({tag, "_in1_first"}, int'(BRIDGE_IN1), int'(DUTY != 0 && !DIR));
        check({tag, "_in2_first"}, int'(BRIDGE_IN2), int'(DUTY != 0 && DIR));
        first_wrap(tag);
    endtask

    task automatic run_periods(input int k);
        for (int i = 0; i < k; i++) begin
            wait_pe();
            repeat ($urandom_range(10, 60)) @(negedge CLOCK_IN);
            #1;
            if (seq_i < 5) DUTY = NW'(duty_seq[seq_i++]);
            else           DUTY = NW'($urandom_range(0, 15));
        end
        wait_pe();
        wait_pe();
    endtask

    task automatic dead_test(input logic new_dir, input bit toggle_back, input string tag);
        int   n = 0;
        logic final_dir;
        wait_pe();
        repeat (20) @(negedge CLOCK_IN);
        #1;
        DUTY = NW'(5);
        DIR  = new_dir;
        final_dir = new_dir;
        @(negedge CLOCK_IN);
        check({tag, "_dead_entry"}, int'({DEAD_ACTIVE, BRIDGE_IN1, BRIDGE_IN2, PWM_OUT}), 8);
        while (DEAD_ACTIVE && n < 100) begin
            n++;
            if (toggle_back && n == 3) begin
                #1 DIR = ~new_dir;
                final_dir = ~new_dir;
            end
            @(negedge CLOCK_IN);
        end
        check_range({tag, "_dead_len"}, n, (DT - 1) * TCYC + 2, DT * TCYC + 1);
        check({tag, "_exit_in1"}, int'(BRIDGE_IN1), int'(!final_dir));
        check({tag, "_exit_in2"}, int'(BRIDGE_IN2), int'(final_dir));
        first_wrap(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CLOCK_IN);
        check("reset_outputs", outs(), 0);
        #1 RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK_IN);
        check("idle_outputs", outs(), 0);
        #1;
        DUTY = NW'(3);
        DIR  = 1'b0;
        enable_start("en0");
        run_periods(7);

        dead_test(1'b1, 1'b0, "rev");
        run_periods(3);
        dead_test(1'b0, 1'b1, "rev_toggle");
        run_periods(2);

        wait_pe();
        #1 DUTY = NW'(12);
        wait_pe();
        repeat (10) @(negedge CLOCK_IN);
        check("pwm_before_drop", int'(PWM_OUT), 1);
        #1 ENABLE = 1'b0;
        @(negedge CLOCK_IN);
        check("disable_outputs", outs(), 0);
        repeat (5) @(negedge CLOCK_IN);
        check("disabled_hold", outs(), 0);
        enable_start("reen");

        wait_pe();
        repeat (15) @(negedge CLOCK_IN);
        check("pwm_before_reset", int'(PWM_OUT), 1);
        @(posedge CLOCK_IN);
        #3 RESET_N = 1'b0;
        #1 check("reset_async_outputs", outs(), 0);
        ENABLE = 1'b0;
        repeat (3) @(negedge CLOCK_IN);
        check("reset_hold_outputs", outs(), 0);
        @(posedge CLOCK_IN);
        #3 RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK_IN);
        check("post_reset_idle", outs(), 0);
        enable_start("post_reset");
        run_periods(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
